// File: rtl/axo_uart_pkg.sv
// Shared definitions for the Axolotl UART transmitter peripheral.
//   - register indices (mem_addr[3:2])
//   - STATUS bit positions
//   - transmit engine state encoding
package axo_uart_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVIDER = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic logic [31:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [31:0] s;
        s                           = '0;
        s[ST_FULL_BIT]              = full;
        s[ST_EMPTY_BIT]             = empty;
        s[ST_BUSY_BIT]              = busy;
        s[ST_OVF_BIT]               = ovf;
        s[ST_COUNT_LSB +: 8]        = count;
        return s;
    endfunction

endpackage

// File: rtl/axo_uart_tx_periph_fifo.sv
// axo_sync_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst       : clock, synchronous active-high reset
//   push/push_data : enqueue; ignored while full
//   pop/pop_data   : dequeue; pop_data shows the head entry combinationally
//   full/empty     : occupancy flags
//   count          : entries held (0..DEPTH)
// DEPTH must be a power of two (pointers wrap naturally).
module axo_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses the push even if a pop happens on the same edge;
    // the freed slot is only usable after that edge.
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/axo_uart_tx_periph.sv
// axo_uart_tx_periph: memory-mapped 8N1 UART transmitter on the Axolotl
// CPU data bus. Stores to DATA enqueue bytes; the engine drains them onto txd.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   mem_re/we    : bus read / write strobes
//   mem_asize    : access size (not used for decode)
//   mem_ready    : responder ready (combinational)
//   mem_addr     : byte address; BASE_ADDR..BASE_ADDR+15 selected
//   mem_data     : bidirectional bus data, driven only on selected reads
//   txd          : serial output, idle high
//   tx_busy      : frame in progress or bytes queued
//
// Register map (mem_addr[3:2]):
//   0 DATA    W: push byte, R: 0
//   1 STATUS  R: {count[15:8], ovf[3], busy[2], empty[1], full[0]}; W clears ovf
//   2 DIVIDER RW [15:0]; bit period = DIVIDER+1 clocks
//   3 reserved
//
// Build option AXO_UART_TX_BLOCKING_EN: when defined, a DATA write to a full
// FIFO stalls via mem_ready until space frees; otherwise it is dropped and
// the sticky overflow flag sets.
//
// TX engine states:
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low)
//   DATA  | data bits, LSB first, bit_idx selects the bit
//   STOP  | stop bit (high); may pop the next byte directly on its last cycle
module axo_uart_tx_periph
    import axo_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [1:0]  mem_asize,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    output logic        txd,
    output logic        tx_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [1:0]    reg_idx;
    logic          data_wr;
    logic          wr_fire;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    count_byte;
    logic [15:0]   divider;
    logic          ovf;
    logic [31:0]   rd_data;
    logic          unused_bits;

    tx_state_t     state;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          txd_q;

    assign sel         = (mem_addr[31:4] == BASE_ADDR[31:4]) && (mem_re || mem_we);
    assign reg_idx     = mem_addr[3:2];
    assign data_wr     = sel && mem_we && (reg_idx == REG_DATA);
    assign unused_bits = ^{mem_asize, mem_addr[1:0], mem_data[31:16]};

`ifdef AXO_UART_TX_BLOCKING_EN
    assign mem_ready = !(data_wr && fifo_full);
`else
    assign mem_ready = 1'b1;
`endif

    assign wr_fire   = sel && mem_we && mem_ready;
    assign fifo_push = wr_fire && (reg_idx == REG_DATA);

    // The engine takes the next byte either from IDLE or on the final cycle
    // of a stop bit, so queued frames run back to back with no idle gap.
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && (baud_cnt == 16'd0)));

    axo_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A 256-deep FIFO reports count 0 when full; the full flag disambiguates.
    assign count_byte = 8'(fifo_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            divider <= DEFAULT_DIV;
        end else if (wr_fire && (reg_idx == REG_DIVIDER)) begin
            divider <= mem_data[15:0];
        end
    end

    // In the blocking build a full-FIFO DATA write never fires, so this
    // set term can only trigger in the dropping build.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_fire && (reg_idx == REG_STATUS)) begin
            ovf <= 1'b0;
        end else if (fifo_push && fifo_full) begin
            ovf <= 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            REG_STATUS:  rd_data = pack_status(fifo_full, fifo_empty,
                                               state != IDLE, ovf, count_byte);
            REG_DIVIDER: rd_data = {16'h0000, divider};
            default:     rd_data = '0;
        endcase
    end

    assign mem_data = (sel && mem_re) ? rd_data : 32'bz;

    // baud_cnt counts down from DIVIDER; a bit ends on the cycle it reads 0,
    // and the next bit reloads from the current DIVIDER value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        shift    <= fifo_dout;
                        baud_cnt <= divider;
                        txd_q    <= 1'b0;
                        state    <= START;
                    end else begin
                        txd_q <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= divider;
                        bit_idx  <= 3'd0;
                        txd_q    <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= divider;
                        if (bit_idx == 3'd7) begin
                            txd_q <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd_q   <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == 16'd0) begin
                        if (fifo_pop) begin
                            shift    <= fifo_dout;
                            baud_cnt <= divider;
                            txd_q    <= 1'b0;
                            state    <= START;
                        end else begin
                            txd_q <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    txd_q <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign txd     = txd_q;
    assign tx_busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_axo_uart_tx_periph.sv
// Self-checking bench for axo_uart_tx_periph. A frame-level model (byte
// queue plus current bit number and cycles left in that bit) predicts txd,
// tx_busy, mem_ready and read data every cycle; directed sections pin the
// model with hand-computed values.
module tb_axo_uart_tx_periph;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  mem_asize;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;
    logic [31:0] tb_wdata;
    logic        tb_drive;
    wire         mem_ready;
    wire         txd;
    wire         tx_busy;

    assign mem_data = tb_drive ? tb_wdata : 32'bz;

    axo_uart_tx_periph #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_asize (mem_asize),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .txd       (txd),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic bound_fail(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mq[$];
    bit          m_active;
    logic [7:0]  m_byte;
    int          m_bit;
    int          m_left;
    logic [15:0] m_div;
    bit          m_ovf;

    function automatic bit tb_sel();
        return (mem_addr[31:4] == BASE[31:4]) && (mem_re || mem_we);
    endfunction

    function automatic logic exp_ready();
`ifdef AXO_UART_TX_BLOCKING_EN
        return !(tb_sel() && mem_we && (mem_addr[3:2] == 2'd0) && (mq.size() == DEPTH));
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic exp_txd();
        if (!m_active) return 1'b1;
        if (m_bit == 0) return 1'b0;
        if (m_bit == 9) return 1'b1;
        return m_byte[m_bit-1];
    endfunction

    function automatic logic [31:0] exp_read();
        logic [31:0] s;
        s = '0;
        case (mem_addr[3:2])
            2'd1: begin
                s[0]    = (mq.size() == DEPTH);
                s[1]    = (mq.size() == 0);
                s[2]    = m_active;
                s[3]    = m_ovf;
                s[15:8] = 8'(mq.size());
            end
            2'd2:    s = {16'h0000, m_div};
            default: s = '0;
        endcase
        return s;
    endfunction

    always @(posedge clk) begin : model_step
        int          qn;
        bit          full_pre;
        int          per_pre;
        bit          acc;
        logic [1:0]  idx;
        logic [31:0] wd;
        qn       = mq.size();
        full_pre = (qn == DEPTH);
        per_pre  = int'(m_div) + 1;
        acc      = tb_sel() && mem_we && exp_ready();
        idx      = mem_addr[3:2];
        wd       = mem_data;
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_bit    = 0;
            m_left   = 0;
            m_ovf    = 1'b0;
            m_div    = 16'd433;
        end else begin
            if (m_active) begin
                m_left--;
                if (m_left == 0) begin
                    m_bit++;
                    if (m_bit == 10) m_active = 1'b0;
                    else m_left = per_pre;
                end
            end
            if (!m_active && qn > 0) begin
                m_byte   = mq.pop_front();
                m_active = 1'b1;
                m_bit    = 0;
                m_left   = per_pre;
            end
            if (acc && idx == 2'd0) begin
                if (!full_pre) mq.push_back(wd[7:0]);
                else m_ovf = 1'b1;
            end
            if (acc && idx == 2'd1) m_ovf = 1'b0;
            if (acc && idx == 2'd2) m_div = wd[15:0];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("txd", txd, exp_txd());
            check("tx_busy", tx_busy, m_active || (mq.size() > 0));
            check("mem_ready", mem_ready, exp_ready());
            if (tb_sel() && mem_re) check("rd_data", mem_data, exp_read());
        end
    end

    // ---------------- bus drivers ----------------
    task automatic bus_idle();
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        tb_drive  = 1'b0;
        mem_addr  = 32'h0;
        tb_wdata  = 32'h0;
        mem_asize = 2'd2;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Leaves the strobe asserted so consecutive calls are gapless.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        int guard;
        guard    = 0;
        mem_re   = 1'b0;
        mem_we   = 1'b1;
        mem_addr = a;
        tb_wdata = d;
        tb_drive = 1'b1;
        forever begin
            @(negedge clk);
            if (mem_ready) break;
            guard++;
            if (guard > 2000) begin
                bound_fail("write_stall");
                break;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        mem_we   = 1'b0;
        tb_drive = 1'b0;
        mem_re   = 1'b1;
        mem_addr = a;
        @(negedge clk);
        d = mem_data;
        @(posedge clk);
        #2;
        bus_idle();
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (tx_busy) begin
            cycles(1);
            guard++;
            if (guard > 5000) begin
                bound_fail(name);
                break;
            end
        end
        cycles(2);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] rd;
        logic        exp_bits [10];
        int          lows;
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        bus_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;

        // reset values and register decode
        bus_read(BASE + 32'h8, rd);
        check("div_reset", rd, 32'h0000_01B1);
        bus_read(BASE + 32'h4, rd);
        check("status_reset", rd, 32'h0000_0002);
        bus_write(BASE + 32'h8, 32'h0001_0007);
        bus_idle();
        bus_read(BASE + 32'h8, rd);
        check("div_upper_masked", rd, 32'h0000_0007);
        bus_read(BASE + 32'hC, rd);
        check("reserved_read", rd, 32'h0);
        bus_read(BASE + 32'h0, rd);
        check("data_read", rd, 32'h0);

        // single frame 0x41 at DIVIDER=3
        bus_write(BASE + 32'h8, 32'd3);
        bus_idle();
        bus_write(BASE, 32'h41);
        bus_idle();
        @(posedge clk);
        @(negedge clk);
        check("frame41_bit0", txd, exp_bits[0]);
        for (int k = 1; k < 10; k++) begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            check($sformatf("frame41_bit%0d", k), txd, exp_bits[k]);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("frame41_busy_last", tx_busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("frame41_busy_drop", tx_busy, 1'b0);
        @(posedge clk);
        #2;

        // two back-to-back frames take exactly 80 cycles
        bus_write(BASE, 32'h55);
        bus_write(BASE, 32'hAA);
        bus_idle();
        repeat (79) @(posedge clk);
        @(negedge clk);
        check("b2b_busy_last", tx_busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_busy_drop", tx_busy, 1'b0);
        @(posedge clk);
        #2;

        // ten writes with no gap into an 8-deep FIFO
        for (int i = 0; i < 10; i++) bus_write(BASE, 32'h10 + i);
        bus_idle();
        bus_read(BASE + 32'h4, rd);
`ifdef AXO_UART_TX_BLOCKING_EN
        check("status_burst", rd, 32'h0000_0805);
`else
        check("status_burst", rd, 32'h0000_080D);
`endif
        bus_write(BASE + 32'h4, 32'hFFFF_FFFF);
        bus_idle();
        bus_read(BASE + 32'h4, rd);
        check("status_ovf_clear", rd, 32'h0000_0805);
        wait_drain("burst_drain");

        // reset during data bit 4 of 0xFF
        bus_write(BASE, 32'hFF);
        bus_idle();
        cycles(21);
        @(negedge clk);
        check("ff_bit4_high", txd, 1'b1);
        @(posedge clk);
        #2;
        check("ff_engine_busy", tx_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_ready", mem_ready, 1'b1);
        @(posedge clk);
        #2;
        bus_read(BASE + 32'h4, rd);
        check("rst_status", rd, 32'h0000_0002);
        bus_read(BASE + 32'h8, rd);
        check("rst_div", rd, 32'h0000_01B1);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("rst_no_residual", lows, 0);
        @(posedge clk);
        #2;

        // randomized traffic, including DIVIDER=0 and mid-frame DIVIDER writes
        bus_write(BASE + 32'h8, 32'd0);
        bus_idle();
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r <= 4) begin
                int n;
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) begin
                    mem_asize = 2'($urandom_range(0, 2));
                    bus_write(BASE | 32'($urandom_range(0, 3)), $urandom);
                end
                bus_idle();
            end else if (r == 5) begin
                bus_write(BASE + 32'h8, {$urandom_range(0, 65535), 16'($urandom_range(0, 4))});
                bus_idle();
            end else if (r == 6 || r == 7) begin
                mem_asize = 2'($urandom_range(0, 2));
                bus_read(BASE + {28'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))}, rd);
            end else if (r == 8) begin
                bus_write(BASE + 32'h4, $urandom);
                bus_idle();
            end else if (r == 9) begin
                bus_write(BASE + 32'hC, $urandom);
                bus_idle();
            end else if (r == 10) begin
                bus_write(BASE + 32'h40, $urandom);
                bus_idle();
            end else begin
                cycles($urandom_range(1, 30));
            end
        end
        wait_drain("random_drain");
        bus_read(BASE + 32'h4, rd);
        check("final_empty", rd[2:0], 3'b010);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
